// File: rtl/regfile_arb_pkg.sv
// Shared types and default sizing for the register-file write arbiter.
// Build option RF_ARB_ZERO_REG_EN (see regfile_write_arbiter) is not used here.
package regfile_arb_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_PTR_W    = $clog2(DEF_NUM_REQ);

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester bus plus register-file write port of the write arbiter.
// master = requester/register-file side, slave = arbiter side.
interface regfile_write_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rf_wr_en;
    logic [ADDR_W-1:0]         rf_wr_addr;
    logic [DATA_W-1:0]         rf_wr_data;
    logic                      init_busy;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, init_busy
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, init_busy
    );
endinterface

// File: rtl/rf_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping modulo NUM_REQ. ptr must be below NUM_REQ.
module rf_rr_pick
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = DEF_PTR_W
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_any
);
    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

    // cand[k] is the requester index examined k-th in priority order
    logic [PTR_W-1:0] cand [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [PTR_W:0] sum;
        assign sum      = {1'b0, ptr} + (PTR_W+1)'(gi);
        assign cand[gi] = (sum >= NUM_REQ_W) ? PTR_W'(sum - NUM_REQ_W) : sum[PTR_W-1:0];
    end

    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid[cand[k]]) begin
                grant_idx = cand[k];
                grant_any = 1'b1;
            end
        end
        grant = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Single write port controller for the register file: zero sweep after reset/clr,
// then round-robin arbitration. Option: RF_ARB_ZERO_REG_EN suppresses writes to addr 0.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    regfile_write_arbiter_if.slave bus
);
    localparam int               PTR_W    = $clog2(NUM_REQ);
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
    localparam logic [PTR_W-1:0]  LAST_REQ = PTR_W'(NUM_REQ - 1);

    arb_state_t        state_reg,   state_next;
    logic [ADDR_W-1:0] count_reg,   count_next;
    logic [PTR_W-1:0]  ptr_reg,     ptr_next;
    logic              wr_en_reg,   wr_en_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [DATA_W-1:0] wr_data_reg, wr_data_next;
    logic [NUM_REQ-1:0] ready;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;

    logic [ADDR_W-1:0] slot_addr [NUM_REQ];
    logic [DATA_W-1:0] slot_data [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
        assign slot_addr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
        assign slot_data[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end

    rf_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .valid     (bus.req_valid),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_INIT;
            count_reg   <= '0;
            ptr_reg     <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            ptr_reg     <= ptr_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        ptr_next     = ptr_reg;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        ready        = '0;
        case (state_reg)
            ST_INIT: begin
                if (clr) begin
                    count_next = '0;
                end else begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = count_reg;
                    wr_data_next = '0;
                    if (count_reg == LAST_REG) begin
                        state_next = ST_ARB;
                        count_next = '0;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            ST_ARB: begin
                // clr beats any pending request: no grant, no write this cycle
                if (clr) begin
                    state_next = ST_INIT;
                    count_next = '0;
                end else if (grant_any) begin
                    ready    = grant;
                    ptr_next = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
`ifdef RF_ARB_ZERO_REG_EN
                    if (slot_addr[grant_idx] != '0) begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = slot_addr[grant_idx];
                        wr_data_next = slot_data[grant_idx];
                    end
`else
                    wr_en_next   = 1'b1;
                    wr_addr_next = slot_addr[grant_idx];
                    wr_data_next = slot_data[grant_idx];
`endif
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign bus.req_ready  = ready;
    assign bus.rf_wr_en   = wr_en_reg;
    assign bus.rf_wr_addr = wr_addr_reg;
    assign bus.rf_wr_data = wr_data_reg;
    assign bus.init_busy  = (state_reg == ST_INIT);
endmodule
